csr_unit_m: RTL and testbench

- Parametrised successor to the single-hart machine-mode CSR file; sits in the writeback stage.
- Adds M/U privilege checking, illegal-access reporting, free-running mcycle and minstret counters, synchronised interrupt inputs, interrupt arbitration, vectored mtvec, and a registered trap/mret redirect FSM.
- The fetch/flush logic consumes the redirect.

---
 rtl/csr_unit_m_pkg.sv | 64 ++++++
 rtl/csr_irq_sync.sv | 63 ++++++
 rtl/csr_unit_m.sv | 228 ++++++++++++++++++++++
 tb/tb_csr_unit_m.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_unit_m_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | csr_unit_m_pkg : shared types, CSR addresses and IRQ causes         |
// | Revision 1.0   : initial release (CSR_MINSTRET_EN selects minstret) |
// +--------------------------------------------------------------------+
package csr_unit_m_pkg;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    WRITE = 2'd1,
    MRET  = 2'd2,
    ERROR = 2'd3
  } state_csr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TRAP = 2'd1,
    RET  = 2'd2
  } trap_fsm_t;

  // Fields are 64 bits wide; narrower builds keep the low XLEN bits.
  typedef struct packed {
    logic [63:0] mstatus;
    logic [63:0] mie;
    logic [63:0] mip;
    logic [63:0] mtvec;
    logic [63:0] mscratch;
    logic [63:0] mepc;
    logic [63:0] mcause;
    logic [63:0] mtval;
    logic [63:0] mcycle;
    logic [63:0] satp;
  } csr_regs_t;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;
  localparam logic [11:0] CSR_SATP     = 12'h180;

  localparam logic [3:0] IRQ_MSI = 4'd3;
  localparam logic [3:0] IRQ_MTI = 4'd7;
  localparam logic [3:0] IRQ_MEI = 4'd11;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MSTATUS_MPP  = 11;

  function automatic logic csr_known(input logic [11:0] addr);
    case (addr)
      CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE,
      CSR_MTVAL, CSR_MIP, CSR_MCYCLE, CSR_MINSTRET, CSR_SATP: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/csr_irq_sync.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | csr_irq_sync : 2-flop interrupt synchroniser and priority encoder   |
// | Revision 1.0 : initial release                                      |
// +--------------------------------------------------------------------+
module csr_irq_sync
  import csr_unit_m_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       irq_sw_i,
  input  logic       irq_timer_i,
  input  logic       irq_ext_i,
  input  logic       msip_i,
  input  logic       msie_i,
  input  logic       mtie_i,
  input  logic       meie_i,
  input  logic       allow_i,
  output logic       ssip_o,
  output logic       mtip_o,
  output logic       meip_o,
  output logic       take_o,
  output logic [3:0] cause_o
);

  logic [2:0] meta_q;
  logic [2:0] sync_q;
  logic       w_pend_msi;
  logic       w_pend_mti;
  logic       w_pend_mei;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= {irq_ext_i, irq_timer_i, irq_sw_i};
      sync_q <= meta_q;
    end
  end

  assign ssip_o = sync_q[0];
  assign mtip_o = sync_q[1];
  assign meip_o = sync_q[2];

  assign w_pend_msi = msie_i & (msip_i | sync_q[0]);
  assign w_pend_mti = mtie_i & sync_q[1];
  assign w_pend_mei = meie_i & sync_q[2];

  // External beats software beats timer.
  always_comb begin
    cause_o = IRQ_MTI;
    if (w_pend_mei) begin
      cause_o = IRQ_MEI;
    end else if (w_pend_msi) begin
      cause_o = IRQ_MSI;
    end
  end

  assign take_o = allow_i & (w_pend_mei | w_pend_msi | w_pend_mti);

endmodule
`default_nettype wire

// File: rtl/csr_unit_m.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | csr_unit_m : M/U CSR file, counters, interrupts, trap/mret redirect |
// | Revision 1.0 : initial release; CSR_MINSTRET_EN adds minstret       |
// +--------------------------------------------------------------------+
module csr_unit_m
  import csr_unit_m_pkg::*;
#(
  parameter int          XLEN        = 64,
  parameter logic [63:0] RESET_MTVEC = 64'h0,
  parameter logic [1:0]  RESET_MODE  = 2'b11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  state_csr_t       st_csr,
  input  logic [11:0]      csr,
  input  logic [2:0]       fun3,
  input  logic             src_zero,
  input  logic [XLEN-1:0]  write_data,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  code,
  input  logic [XLEN-1:0]  tval,
  input  logic             instret,
  input  logic             irq_sw,
  input  logic             irq_timer,
  input  logic             irq_ext,
  output logic [XLEN-1:0]  csr_value,
  output logic             illegal,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [1:0]       mode_now,
  output logic [XLEN-1:0]  satp_out,
  output logic             busy
);

  localparam logic [XLEN-1:0] ALIGN4 = ~XLEN'(3);
  localparam csr_regs_t REGS_RST = '{mtvec: 64'(RESET_MTVEC[XLEN-1:0]), default: '0};

  csr_regs_t       regs_q, regs_d;
  trap_fsm_t       state_q, state_d;
  logic [1:0]      mode_q, mode_d;
  logic [XLEN-1:0] rpc_q, rpc_d;

  logic [XLEN-1:0] w_rdata;
  logic [XLEN-1:0] w_new;
  logic [XLEN-1:0] w_mip_hw;
  logic [XLEN-1:0] w_minstret;
  logic [XLEN-1:0] w_voff;
  logic [XLEN-2:0] w_cause_lo;
  logic [3:0]      w_irq_cause;
  logic            w_known, w_intent, w_allow_irq, w_take;
  logic            w_exc, w_ret, w_trap, w_we;
  logic            w_ssip, w_mtip, w_meip;
  logic            w_unused;

  csr_irq_sync u_irq (
    .clk         (clk),
    .rst         (rst),
    .irq_sw_i    (irq_sw),
    .irq_timer_i (irq_timer),
    .irq_ext_i   (irq_ext),
    .msip_i      (regs_q.mip[3]),
    .msie_i      (regs_q.mie[3]),
    .mtie_i      (regs_q.mie[7]),
    .meie_i      (regs_q.mie[11]),
    .allow_i     (w_allow_irq),
    .ssip_o      (w_ssip),
    .mtip_o      (w_mtip),
    .meip_o      (w_meip),
    .take_o      (w_take),
    .cause_o     (w_irq_cause)
  );

  always_comb begin
    w_mip_hw     = '0;
    w_mip_hw[3]  = w_ssip;
    w_mip_hw[7]  = w_mtip;
    w_mip_hw[11] = w_meip;
  end

  always_comb begin
    w_rdata = '0;
    case (csr)
      CSR_MSTATUS:  w_rdata = regs_q.mstatus[XLEN-1:0];
      CSR_MIE:      w_rdata = regs_q.mie[XLEN-1:0];
      CSR_MIP:      w_rdata = regs_q.mip[XLEN-1:0] | w_mip_hw;
      CSR_MTVEC:    w_rdata = regs_q.mtvec[XLEN-1:0];
      CSR_MSCRATCH: w_rdata = regs_q.mscratch[XLEN-1:0];
      CSR_MEPC:     w_rdata = regs_q.mepc[XLEN-1:0];
      CSR_MCAUSE:   w_rdata = regs_q.mcause[XLEN-1:0];
      CSR_MTVAL:    w_rdata = regs_q.mtval[XLEN-1:0];
      CSR_MCYCLE:   w_rdata = regs_q.mcycle[XLEN-1:0];
      CSR_MINSTRET: w_rdata = w_minstret;
      CSR_SATP:     w_rdata = regs_q.satp[XLEN-1:0];
      default:      w_rdata = '0;
    endcase
  end

  assign w_known  = csr_known(csr);
  assign w_intent = (fun3[1:0] == 2'b01) | ((fun3[1:0] != 2'b00) & ~src_zero);
  assign illegal  = (st_csr == WRITE) &
                    ((csr[9:8] > mode_q) | ((csr[11:10] == 2'b11) & w_intent) | ~w_known);

  always_comb begin
    case (fun3[1:0])
      2'b01:   w_new = write_data;
      2'b10:   w_new = w_rdata | write_data;
      2'b11:   w_new = w_rdata & ~write_data;
      default: w_new = w_rdata;
    endcase
  end

  assign busy        = (state_q != IDLE);
  assign w_allow_irq = en & ~busy & (st_csr != ERROR) & (st_csr != MRET) &
                       ((mode_q != 2'b11) | regs_q.mstatus[MSTATUS_MIE]);
  assign w_exc       = en & ~busy & (st_csr == ERROR);
  assign w_ret       = en & ~busy & (st_csr == MRET);
  assign w_trap      = w_exc | w_take;
  assign w_we        = en & ~busy & (st_csr == WRITE) & ~illegal & w_intent & ~w_take;
  assign w_cause_lo  = w_take ? (XLEN-1)'(w_irq_cause) : code[XLEN-2:0];
  assign w_voff      = (w_take & regs_q.mtvec[0]) ? XLEN'({w_irq_cause, 2'b00}) : '0;

  always_comb begin
    regs_d        = regs_q;
    mode_d        = mode_q;
    regs_d.mcycle = 64'(regs_q.mcycle[XLEN-1:0] + XLEN'(1));
    if (w_trap) begin
      regs_d.mepc                        = 64'(pc & ALIGN4);
      regs_d.mcause                      = 64'({w_take, w_cause_lo});
      regs_d.mtval                       = w_take ? '0 : 64'(tval);
      regs_d.mstatus[MSTATUS_MPIE]       = regs_q.mstatus[MSTATUS_MIE];
      regs_d.mstatus[MSTATUS_MIE]        = 1'b0;
      regs_d.mstatus[MSTATUS_MPP +: 2]   = mode_q;
      mode_d                             = 2'b11;
    end else if (w_ret) begin
      regs_d.mstatus[MSTATUS_MIE]        = regs_q.mstatus[MSTATUS_MPIE];
      regs_d.mstatus[MSTATUS_MPIE]       = 1'b1;
      regs_d.mstatus[MSTATUS_MPP +: 2]   = 2'b00;
      mode_d                             = regs_q.mstatus[MSTATUS_MPP +: 2];
    end else if (w_we) begin
      case (csr)
        CSR_MSTATUS:  regs_d.mstatus  = 64'(w_new);
        CSR_MIE:      regs_d.mie      = 64'(w_new);
        CSR_MIP: begin
          regs_d.mip    = '0;
          regs_d.mip[3] = w_new[3];
        end
        CSR_MTVEC:    regs_d.mtvec    = 64'(w_new & ~XLEN'(2));
        CSR_MSCRATCH: regs_d.mscratch = 64'(w_new);
        CSR_MEPC:     regs_d.mepc     = 64'(w_new & ALIGN4);
        CSR_MCAUSE:   regs_d.mcause   = 64'(w_new);
        CSR_MTVAL:    regs_d.mtval    = 64'(w_new);
        CSR_MCYCLE:   regs_d.mcycle   = 64'(w_new);
        CSR_SATP:     regs_d.satp     = 64'(w_new);
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    rpc_d   = rpc_q;
    case (state_q)
      IDLE: begin
        if (w_trap) begin
          state_d = TRAP;
          rpc_d   = (regs_q.mtvec[XLEN-1:0] & ALIGN4) + w_voff;
        end else if (w_ret) begin
          state_d = RET;
          rpc_d   = regs_q.mepc[XLEN-1:0];
        end
      end
      TRAP, RET: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q  <= REGS_RST;
      mode_q  <= RESET_MODE;
      state_q <= IDLE;
      rpc_q   <= '0;
    end else begin
      regs_q  <= regs_d;
      mode_q  <= mode_d;
      state_q <= state_d;
      rpc_q   <= rpc_d;
    end
  end

`ifdef CSR_MINSTRET_EN
  logic [XLEN-1:0] minstret_q, minstret_d;

  // A pre-empting interrupt means the instruction did not retire.
  always_comb begin
    minstret_d = minstret_q;
    if (w_we && (csr == CSR_MINSTRET)) begin
      minstret_d = w_new;
    end else if (en && instret && !busy && !w_take) begin
      minstret_d = minstret_q + XLEN'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      minstret_q <= '0;
    end else begin
      minstret_q <= minstret_d;
    end
  end

  assign w_minstret = minstret_q;
  assign w_unused   = ^{fun3[2], code[XLEN-1]};
`else
  assign w_minstret = '0;
  assign w_unused   = ^{fun3[2], code[XLEN-1], instret};
`endif

  assign csr_value      = w_rdata;
  assign redirect_valid = busy;
  assign redirect_pc    = rpc_q;
  assign mode_now       = mode_q;
  assign satp_out       = regs_q.satp[XLEN-1:0];

endmodule
`default_nettype wire

// File: tb/tb_csr_unit_m.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_csr_unit_m : directed vector bench for csr_unit_m                |
// | Revision 1.0  : initial release                                     |
// +--------------------------------------------------------------------+
module tb_csr_unit_m;
  import csr_unit_m_pkg::*;

  localparam int          XLEN     = 64;
  localparam logic [63:0] RST_TVEC = 64'h100;
`ifdef CSR_MINSTRET_EN
  localparam logic [63:0] EXP_MINSTRET = 64'd5;
`else
  localparam logic [63:0] EXP_MINSTRET = 64'd0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  state_csr_t       st_csr;
  logic [11:0]      csr;
  logic [2:0]       fun3;
  logic             src_zero;
  logic [XLEN-1:0]  write_data, pc, code, tval;
  logic             instret, irq_sw, irq_timer, irq_ext;
  logic [XLEN-1:0]  csr_value;
  logic             illegal;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic [1:0]       mode_now;
  logic [XLEN-1:0]  satp_out;
  logic             busy;

  csr_unit_m #(.XLEN(XLEN), .RESET_MTVEC(RST_TVEC), .RESET_MODE(2'b11)) dut (
    .clk(clk), .rst(rst), .en(en), .st_csr(st_csr), .csr(csr), .fun3(fun3),
    .src_zero(src_zero), .write_data(write_data), .pc(pc), .code(code), .tval(tval),
    .instret(instret), .irq_sw(irq_sw), .irq_timer(irq_timer), .irq_ext(irq_ext),
    .csr_value(csr_value), .illegal(illegal), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .mode_now(mode_now), .satp_out(satp_out), .busy(busy)
  );

  always #10 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic rd(input logic [11:0] a, input logic [63:0] exp, input string name);
    en     = 1'b0;
    st_csr = NONE;
    csr    = a;
    #1;
    chk(name, csr_value, exp);
  endtask

  task automatic wr(input logic [11:0] a, input logic [2:0] f, input logic [63:0] d);
    en         = 1'b1;
    st_csr     = WRITE;
    csr        = a;
    fun3       = f;
    src_zero   = 1'b0;
    write_data = d;
    @(negedge clk);
    en     = 1'b0;
    st_csr = NONE;
  endtask

  typedef struct {
    state_csr_t  st;
    logic [11:0] a;
    logic [2:0]  f;
    logic        sz;
    logic [63:0] wd;
    logic        en;
    logic [63:0] exp_rd;
    logic        exp_ill;
  } vec_t;

  localparam int NV = 20;
  vec_t tbl [NV];

  initial begin
    tbl[0]  = '{WRITE, CSR_MSCRATCH, 3'b001, 1'b0, 64'hA5,   1'b1, 64'h0,    1'b0};
    tbl[1]  = '{WRITE, CSR_MSCRATCH, 3'b010, 1'b0, 64'h0F,   1'b1, 64'hA5,   1'b0};
    tbl[2]  = '{WRITE, CSR_MSCRATCH, 3'b011, 1'b0, 64'hA0,   1'b1, 64'hAF,   1'b0};
    tbl[3]  = '{WRITE, CSR_MSCRATCH, 3'b010, 1'b1, 64'hFF,   1'b1, 64'h0F,   1'b0};
    tbl[4]  = '{NONE,  CSR_MSCRATCH, 3'b000, 1'b0, 64'h0,    1'b0, 64'h0F,   1'b0};
    tbl[5]  = '{WRITE, CSR_MTVEC,    3'b001, 1'b0, 64'h1003, 1'b1, RST_TVEC, 1'b0};
    tbl[6]  = '{NONE,  CSR_MTVEC,    3'b000, 1'b0, 64'h0,    1'b0, 64'h1001, 1'b0};
    tbl[7]  = '{WRITE, CSR_MEPC,     3'b001, 1'b0, 64'h207,  1'b1, 64'h0,    1'b0};
    tbl[8]  = '{NONE,  CSR_MEPC,     3'b000, 1'b0, 64'h0,    1'b0, 64'h204,  1'b0};
    tbl[9]  = '{WRITE, CSR_MIP,      3'b001, 1'b0, 64'hFFFF, 1'b1, 64'h0,    1'b0};
    tbl[10] = '{NONE,  CSR_MIP,      3'b000, 1'b0, 64'h0,    1'b0, 64'h8,    1'b0};
    tbl[11] = '{WRITE, CSR_MIP,      3'b011, 1'b0, 64'h8,    1'b1, 64'h8,    1'b0};
    tbl[12] = '{NONE,  CSR_MIP,      3'b000, 1'b0, 64'h0,    1'b0, 64'h0,    1'b0};
    tbl[13] = '{WRITE, 12'h7C0,      3'b001, 1'b0, 64'h1,    1'b1, 64'h0,    1'b1};
    tbl[14] = '{WRITE, CSR_SATP,     3'b001, 1'b0, 64'h1234, 1'b1, 64'h0,    1'b0};
    tbl[15] = '{NONE,  CSR_SATP,     3'b000, 1'b0, 64'h0,    1'b0, 64'h1234, 1'b0};
    tbl[16] = '{WRITE, CSR_MINSTRET, 3'b001, 1'b0, 64'h5,    1'b1, 64'h0,    1'b0};
    tbl[17] = '{NONE,  CSR_MINSTRET, 3'b000, 1'b0, 64'h0,    1'b0, EXP_MINSTRET, 1'b0};
    tbl[18] = '{WRITE, CSR_MSTATUS,  3'b001, 1'b0, 64'h8,    1'b0, 64'h0,    1'b0};
    tbl[19] = '{NONE,  CSR_MSTATUS,  3'b000, 1'b0, 64'h0,    1'b0, 64'h0,    1'b0};

    rst = 1'b1; en = 1'b0; st_csr = NONE; csr = '0; fun3 = '0; src_zero = 1'b0;
    write_data = '0; pc = '0; code = '0; tval = '0; instret = 1'b0;
    irq_sw = 1'b0; irq_timer = 1'b0; irq_ext = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_mode", 64'(mode_now), 64'h3);
    chk("rst_rv", 64'(redirect_valid), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_rpc", redirect_pc, 64'h0);
    rd(CSR_MTVEC, RST_TVEC, "rst_mtvec");
    rd(CSR_MSCRATCH, 64'h0, "rst_mscratch");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      st_csr     = tbl[i].st;
      csr        = tbl[i].a;
      fun3       = tbl[i].f;
      src_zero   = tbl[i].sz;
      write_data = tbl[i].wd;
      en         = tbl[i].en;
      #1;
      chk($sformatf("vec%0d_rd", i), csr_value, tbl[i].exp_rd);
      chk($sformatf("vec%0d_ill", i), 64'(illegal), 64'(tbl[i].exp_ill));
      @(negedge clk);
    end
    en = 1'b0; st_csr = NONE; src_zero = 1'b0;
    chk("satp_out", satp_out, 64'h1234);

    // mcycle: write wins, then free-running increment
    wr(CSR_MCYCLE, 3'b001, 64'd5);
    rd(CSR_MCYCLE, 64'd5, "mcycle_wr");
    @(negedge clk);
    rd(CSR_MCYCLE, 64'd6, "mcycle_inc");

    // vectored external interrupt pre-empting a retiring instruction
    wr(CSR_MIE, 3'b001, 64'h800);
    wr(CSR_MSTATUS, 3'b001, 64'h8);
    irq_ext = 1'b1;
    repeat (2) @(negedge clk);
    rd(CSR_MIP, 64'h800, "irq_mip");
    en = 1'b1; st_csr = NONE; pc = 64'h4000; instret = 1'b1;
    @(negedge clk);
    en = 1'b0; instret = 1'b0;
    #1;
    chk("irq_rv", 64'(redirect_valid), 64'h1);
    chk("irq_busy", 64'(busy), 64'h1);
    chk("irq_rpc", redirect_pc, 64'h102C);
    chk("irq_mode", 64'(mode_now), 64'h3);
    rd(CSR_MCAUSE, 64'h8000_0000_0000_000B, "irq_mcause");
    rd(CSR_MEPC, 64'h4000, "irq_mepc");
    rd(CSR_MTVAL, 64'h0, "irq_mtval");
    rd(CSR_MSTATUS, 64'h1880, "irq_mstatus");
    en = 1'b1; st_csr = WRITE; csr = CSR_MSCRATCH; fun3 = 3'b001; write_data = 64'hDEAD;
    @(negedge clk);
    en = 1'b0; st_csr = NONE; irq_ext = 1'b0;
    #1;
    chk("irq_rv_drop", 64'(redirect_valid), 64'h0);
    rd(CSR_MSCRATCH, 64'h0F, "trap_en_ignored");
    rd(CSR_MINSTRET, EXP_MINSTRET, "irq_no_retire");

    // exception together with a pending timer interrupt
    wr(CSR_MIE, 3'b001, 64'h80);
    wr(CSR_MSTATUS, 3'b001, 64'h8);
    irq_timer = 1'b1;
    repeat (2) @(negedge clk);
    rd(CSR_MIP, 64'h80, "sim_mip");
    en = 1'b1; st_csr = ERROR; code = 64'd2; tval = 64'h55; pc = 64'h5000;
    @(negedge clk);
    en = 1'b0; st_csr = NONE;
    #1;
    chk("sim_rv", 64'(redirect_valid), 64'h1);
    chk("sim_rpc", redirect_pc, 64'h1000);
    rd(CSR_MCAUSE, 64'd2, "sim_mcause");
    rd(CSR_MTVAL, 64'h55, "sim_mtval");
    rd(CSR_MEPC, 64'h5000, "sim_mepc");
    en = 1'b1; st_csr = MRET; irq_timer = 1'b0;
    @(negedge clk);
    en = 1'b0; st_csr = NONE;
    #1;
    chk("sim_mret_ignored", 64'(redirect_valid), 64'h0);
    chk("sim_mode", 64'(mode_now), 64'h3);

    // MRET into U-mode, illegal accesses there, trap and return
    wr(CSR_MIE, 3'b001, 64'h0);
    wr(CSR_MSTATUS, 3'b001, 64'h80);
    wr(CSR_MEPC, 3'b001, 64'h3000);
    en = 1'b1; st_csr = MRET;
    @(negedge clk);
    en = 1'b0; st_csr = NONE;
    #1;
    chk("ret_rv", 64'(redirect_valid), 64'h1);
    chk("ret_rpc", redirect_pc, 64'h3000);
    chk("ret_mode", 64'(mode_now), 64'h0);
    @(negedge clk);
    rd(CSR_MSTATUS, 64'h88, "ret_mstatus");
    en = 1'b1; st_csr = WRITE; csr = CSR_MSTATUS; fun3 = 3'b001; write_data = 64'h0;
    #1;
    chk("u_ill_mstatus", 64'(illegal), 64'h1);
    @(negedge clk);
    csr = CSR_SATP; write_data = 64'hFFFF;
    #1;
    chk("u_ill_satp", 64'(illegal), 64'h1);
    @(negedge clk);
    rd(CSR_MSTATUS, 64'h88, "u_mstatus_kept");
    rd(CSR_SATP, 64'h1234, "u_satp_kept");
    en = 1'b1; st_csr = ERROR; code = 64'd8; tval = 64'h0; pc = 64'h6000;
    @(negedge clk);
    en = 1'b0; st_csr = NONE;
    #1;
    chk("u_trap_rpc", redirect_pc, 64'h1000);
    chk("u_trap_mode", 64'(mode_now), 64'h3);
    rd(CSR_MCAUSE, 64'd8, "u_trap_mcause");
    rd(CSR_MEPC, 64'h6000, "u_trap_mepc");
    rd(CSR_MSTATUS, 64'h80, "u_trap_mstatus");
    @(negedge clk);
    en = 1'b1; st_csr = MRET;
    @(negedge clk);
    en = 1'b0; st_csr = NONE;
    #1;
    chk("u_ret_rpc", redirect_pc, 64'h6000);
    chk("u_ret_mode", 64'(mode_now), 64'h0);
    rd(CSR_MSTATUS, 64'h88, "u_ret_mstatus");

    // asynchronous reset in the middle of a TRAP cycle
    @(negedge clk);
    en = 1'b1; st_csr = ERROR; code = 64'd3; pc = 64'h7000;
    @(negedge clk);
    en = 1'b0; st_csr = NONE;
    #1;
    chk("pre_rst_rv", 64'(redirect_valid), 64'h1);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_rv", 64'(redirect_valid), 64'h0);
    chk("async_rst_busy", 64'(busy), 64'h0);
    chk("async_rst_mode", 64'(mode_now), 64'h3);
    chk("async_rst_rpc", redirect_pc, 64'h0);
    rd(CSR_MTVEC, RST_TVEC, "async_rst_mtvec");
    rd(CSR_MSCRATCH, 64'h0, "async_rst_mscratch");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("post_rst_rv", 64'(redirect_valid), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
